// File: rtl/rptr_handler_fwft.sv
// Read-side pointer handler for an async FIFO with first-word-fall-through
// output. It fetches words from the memory ahead of the consumer into a
// 2-entry skid buffer, so the head word is presented on dout and popped with
// dout_ready. It also maintains the binary/Gray read pointers, the empty flag,
// the read level and the almost-empty flag.
module rptr_handler_fwft #(
  parameter int PTR_WIDTH  = 5,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [PTR_WIDTH:0]    g_wptr_sync,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  dout_ready,
  output logic                  mem_rd_en,
  output logic [PTR_WIDTH-1:0]  raddr,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [PTR_WIDTH:0]    rd_level,
  output logic                  almost_empty
);

  localparam logic [PTR_WIDTH:0] AE_LVL = (PTR_WIDTH + 1)'(AE_THRESH);

  logic [PTR_WIDTH:0]    b_rptr_next;
  logic [PTR_WIDTH:0]    g_rptr_next;
  logic [PTR_WIDTH:0]    b_wptr_sync;
  logic [PTR_WIDTH:0]    level_next;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            occ;
  logic [1:0]            buf_cnt;
  logic [1:0]            buf_cnt_next;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] tail_next;

  assign raddr = b_rptr[PTR_WIDTH-1:0];

  // Fetch only while the buffer plus the in-flight word, after this cycle's
  // pop, leaves room, so the skid buffer can never overflow.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so each path drives each signal and no latch is inferred.
    pop       = dout_valid & dout_ready;
    occ       = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    mem_rd_en = !empty && (occ < 3'd2);
  end

  // Next read pointers (binary and Gray) and the level they leave behind.
  always_comb begin
    b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, mem_rd_en};
    g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;
    level_next  = b_wptr_sync - b_rptr_next;
  end

  // Gray-to-binary: each binary bit is the XOR of its Gray bit and all above.
  always_comb begin
    b_wptr_sync = '0;
    for (int i = 0; i <= PTR_WIDTH; i++) begin
      b_wptr_sync[i] = ^(g_wptr_sync >> i);
    end
  end

  // Skid-buffer next state: pop shifts the tail into the head, and the
  // arriving word lands in the first free slot after the pop, keeping order.
  always_comb begin
    buf_cnt_next = buf_cnt + {1'b0, inflight} - {1'b0, pop};
    head_next    = dout;
    tail_next    = tail_q;
    if (pop) begin
      head_next = tail_q;
    end
    if (inflight) begin
      if ((buf_cnt - {1'b0, pop}) == 2'd0) begin
        head_next = mem_rdata;
      end else begin
        tail_next = mem_rdata;
      end
    end
  end

  // Pointer, status-flag and in-flight registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    // NOTE: sequential blocks use non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    if (!rrst_n) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      rd_level     <= '0;
      almost_empty <= 1'b1;
      inflight     <= 1'b0;
    end else begin
      b_rptr       <= b_rptr_next;
      g_rptr       <= g_rptr_next;
      empty        <= (g_rptr_next == g_wptr_sync);
      rd_level     <= level_next;
      almost_empty <= (level_next <= AE_LVL);
      inflight     <= mem_rd_en;
    end
  end

  // Skid-buffer storage; dout is the head entry itself.
  always_ff @(posedge rclk or negedge rrst_n) begin
    // NOTE: the buffer data is reset too, so no stale word is visible on
    // dout after a mid-stream reset; it is only two words, so this is cheap.
    if (!rrst_n) begin
      buf_cnt    <= '0;
      dout       <= '0;
      tail_q     <= '0;
      dout_valid <= 1'b0;
    end else begin
      buf_cnt    <= buf_cnt_next;
      dout       <= head_next;
      tail_q     <= tail_next;
      dout_valid <= (buf_cnt_next != 2'd0);
    end
  end

endmodule

// File: tb/tb_rptr_handler_fwft.sv
// Testbench for rptr_handler_fwft. The bench plays the write side and the
// memory. A transaction-level model tracks counts of words written, fetched,
// arrived and popped. Every DUT output is compared against that model on
// every falling edge. Directed sequences pin the model with literal values.
`timescale 1ns/1ps
module tb_rptr_handler_fwft;

  localparam int PW   = 5;
  localparam int DW   = 8;
  localparam int AE   = 4;
  localparam int MASK = (1 << (PW + 1)) - 1;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b1;
  logic [PW:0]   g_wptr_sync = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          dout_ready = 1'b0;
  logic          mem_rd_en;
  logic [PW-1:0] raddr;
  logic [PW:0]   b_rptr;
  logic [PW:0]   g_rptr;
  logic          empty;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [PW:0]   rd_level;
  logic          almost_empty;

  rptr_handler_fwft #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .AE_THRESH(AE)) dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .g_wptr_sync  (g_wptr_sync),
    .mem_rdata    (mem_rdata),
    .dout_ready   (dout_ready),
    .mem_rd_en    (mem_rd_en),
    .raddr        (raddr),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .empty        (empty),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .rd_level     (rd_level),
    .almost_empty (almost_empty)
  );

  bit clk_run = 1'b0;
  initial forever begin
    #5;
    if (clk_run) rclk = ~rclk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Write side and memory contents, owned by the bench.
  int            wr_cnt = 0;
  logic [DW-1:0] data_arr [int];
  logic [DW-1:0] mem [32];

  // Model counters: words fetched, arrived in the buffer, popped, and the
  // write count seen at the last edge.
  int m_f = 0;
  int m_a = 0;
  int m_p = 0;
  int m_w = 0;

  function automatic logic [PW:0] gray(input int v);
    logic [PW:0] b;
    b = v[PW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #2;
  endtask

  task automatic push_word();
    logic [DW-1:0] d;
    d = DW'($urandom);
    mem[wr_cnt % 32] = d;
    data_arr[wr_cnt] = d;
    wr_cnt++;
    g_wptr_sync = gray(wr_cnt);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    wr_cnt = 0;
    g_wptr_sync = '0;
    data_arr.delete();
    tick();
    tick();
    rrst_n = 1'b1;
  endtask

  // Memory: data appears one cycle after the fetch strobe, garbage otherwise.
  always @(posedge rclk) begin
    mem_rdata <= mem_rd_en ? mem[raddr] : DW'($urandom);
  end

  // Per-cycle compare against the count model, then advance the model.
  initial begin
    bit e_pop;
    bit e_fetch;
    bit e_valid;
    int lvl;
    forever begin
      @(negedge rclk);
      e_pop = 1'b0;
      e_fetch = 1'b0;
      if (!rrst_n) begin
        m_f = 0; m_a = 0; m_p = 0; m_w = 0;
        check("rst_b_rptr", b_rptr, 0);
        check("rst_g_rptr", g_rptr, 0);
        check("rst_empty", empty, 1);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_rd_level", rd_level, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_mem_rd_en", mem_rd_en, 0);
      end else begin
        lvl     = (m_w - m_f) & MASK;
        e_valid = (m_a > m_p);
        e_pop   = e_valid && dout_ready;
        e_fetch = (m_f != m_w) && (((m_f - m_p) - int'(e_pop)) < 2);
        check("b_rptr", b_rptr, m_f & MASK);
        check("g_rptr", g_rptr, gray(m_f));
        check("raddr", raddr, m_f % 32);
        check("empty", empty, m_f == m_w);
        check("rd_level", rd_level, lvl);
        check("almost_empty", almost_empty, lvl <= AE);
        check("dout_valid", dout_valid, e_valid);
        if (e_valid) check("dout", dout, data_arr[m_p]);
        check("mem_rd_en", mem_rd_en, e_fetch);
      end
      @(posedge rclk);
      if (!rrst_n) begin
        m_f = 0; m_a = 0; m_p = 0; m_w = 0;
      end else begin
        if (e_pop) m_p++;
        m_a = m_f;
        if (e_fetch) m_f++;
        m_w = wr_cnt;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w0;
    bit saw31;
    bit saw32;

    // Reset with the clock stopped and arbitrary inputs.
    g_wptr_sync = 6'h2a;
    dout_ready  = 1'b1;
    #3 rrst_n = 1'b0;
    #1;
    check("stopped_rst_b_rptr", b_rptr, 0);
    check("stopped_rst_g_rptr", g_rptr, 0);
    check("stopped_rst_empty", empty, 1);
    check("stopped_rst_dout_valid", dout_valid, 0);
    check("stopped_rst_dout", dout, 0);
    check("stopped_rst_rd_level", rd_level, 0);
    check("stopped_rst_almost_empty", almost_empty, 1);
    check("stopped_rst_mem_rd_en", mem_rd_en, 0);
    g_wptr_sync = '0;
    clk_run = 1'b1;
    tick(); tick(); tick();
    rrst_n = 1'b1;
    tick(); tick(); tick();

    // Single word: fetch one cycle after empty drops, valid 3 cycles after.
    dout_ready = 1'b1;
    push_word();
    w0 = data_arr[0];
    @(negedge rclk);
    check("sw_no_fetch_yet", mem_rd_en, 0);
    @(negedge rclk);
    check("sw_fetch", mem_rd_en, 1);
    check("sw_raddr", raddr, 0);
    @(negedge rclk);
    check("sw_fetch_done", mem_rd_en, 0);
    check("sw_b_rptr", b_rptr, 1);
    check("sw_g_rptr", g_rptr, 1);
    check("sw_empty", empty, 1);
    check("sw_not_valid_yet", dout_valid, 0);
    @(negedge rclk);
    check("sw_valid", dout_valid, 1);
    check("sw_dout", dout, w0);
    @(negedge rclk);
    check("sw_valid_one_cycle", dout_valid, 0);
    tick();

    // Backpressure: 8 words, consumer stalled, then released.
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_word();
      tick();
    end
    repeat (6) tick();
    @(negedge rclk);
    check("bp_b_rptr", b_rptr, 2);
    check("bp_rd_level", rd_level, 6);
    check("bp_almost_empty", almost_empty, 0);
    check("bp_valid", dout_valid, 1);
    check("bp_dout_held", dout, data_arr[0]);
    check("bp_no_fetch", mem_rd_en, 0);
    tick();
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk);
      check("bp_drain_valid", dout_valid, 1);
      check("bp_drain_dout", dout, data_arr[i]);
      tick();
    end
    @(negedge rclk);
    check("bp_drained", dout_valid, 0);
    tick();

    // Almost-empty threshold: level 5 -> 4 after one more fetch.
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push_word();
      tick();
    end
    repeat (6) tick();
    @(negedge rclk);
    check("ae_level5", rd_level, 5);
    check("ae_flag_low", almost_empty, 0);
    tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    @(negedge rclk);
    check("ae_level4", rd_level, 4);
    check("ae_flag_high", almost_empty, 1);
    check("ae_b_rptr", b_rptr, 3);
    tick();
    dout_ready = 1'b1;
    repeat (12) tick();

    // Mid-stream reset while words are buffered and in flight.
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word();
      tick();
    end
    #1 rrst_n = 1'b0;
    #1;
    check("mid_rst_b_rptr", b_rptr, 0);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_mem_rd_en", mem_rd_en, 0);
    wr_cnt = 0;
    g_wptr_sync = '0;
    data_arr.delete();
    tick(); tick();
    rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      check("post_rst_no_valid", dout_valid, 0);
      check("post_rst_dout_clear", dout, 0);
    end
    tick();

    // Wrap-around: 40 words streamed back to back.
    do_reset();
    dout_ready = 1'b1;
    saw31 = 1'b0;
    saw32 = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (c < 40) push_word();
      @(negedge rclk);
      if (b_rptr == 6'd31) begin
        saw31 = 1'b1;
        check("wrap_g31", g_rptr, 6'b010000);
        check("wrap_raddr31", raddr, 31);
      end
      if (b_rptr == 6'd32) begin
        saw32 = 1'b1;
        check("wrap_g32", g_rptr, 6'b110000);
        check("wrap_raddr0", raddr, 0);
      end
      tick();
      if (c == 42) check("wrap_throughput_popped", m_p, 40);
    end
    check("wrap_saw31", saw31, 1);
    check("wrap_saw32", saw32, 1);
    @(negedge rclk);
    check("wrap_final_b_rptr", b_rptr, 40);
    check("wrap_final_empty", empty, 1);
    tick();

    // Random traffic with random backpressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      dout_ready = ($urandom_range(99) < 65);
      if ($urandom_range(1) == 1 && (wr_cnt - m_p) < 32) push_word();
      if ($urandom_range(999) == 0) do_reset();
      tick();
    end

    // Drain everything that was written.
    dout_ready = 1'b1;
    for (int i = 0; i < 200 && m_p != wr_cnt; i++) tick();
    check("drain_all_words", m_p, wr_cnt);
    tick();
    @(negedge rclk);
    check("final_empty", empty, 1);
    check("final_no_valid", dout_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
